// File: rtl/row_window_shifter_if.sv
// rtl/row_window_shifter_if.sv - BRAM read port between the row window shifter and the BRAM read controller.
interface row_window_shifter_if #(
    parameter int BRAM_DW = 32,
    parameter int BRAM_AW = 13
);
    logic [BRAM_AW-1:0] o_bram_addr;
    logic [BRAM_DW-1:0] i_bram_data;
    logic               o_bram_trig;
    logic               i_bram_done;

    modport master (
        output o_bram_addr,
        output o_bram_trig,
        input  i_bram_data,
        input  i_bram_done
    );

    modport slave (
        input  o_bram_addr,
        input  o_bram_trig,
        output i_bram_data,
        output i_bram_done
    );
endinterface

// File: rtl/row_window_shifter.sv
// rtl/row_window_shifter.sv - NUM_ROWS-deep sliding row window fed word by word from BRAM.
// The visible window only changes on the COMMIT edge; new rows are assembled in a staging buffer.
module row_window_shifter #(
    parameter int ROW_BITS     = 512,
    parameter int NUM_ROWS     = 3,
    parameter int ROW_AW       = 9,
    parameter int BRAM_DW      = 32,
    parameter int BRAM_AW      = 13,
    parameter int NUM_IMG_ROWS = 512
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_trig,
    input  logic [1:0]                   i_mode,
    input  logic [ROW_AW-1:0]            i_row_num,
    input  logic [ROW_BITS-1:0]          i_start_row_data,
    output logic                         o_done,
    output logic                         o_busy,
    output logic [NUM_ROWS*ROW_BITS-1:0] o_window,
    row_window_shifter_if.master         bram
);
    localparam int W   = ROW_BITS / BRAM_DW;
    localparam int WAW = $clog2(W);
    localparam int TIW = $clog2(NUM_ROWS);
    localparam int RXW = ROW_AW + TIW;
    localparam int SIW = $clog2((NUM_ROWS - 1) * ROW_BITS);
    localparam logic [WAW-1:0] LAST_WORD = WAW'(W - 1);
    localparam logic [RXW-1:0] IMG_ROWS  = RXW'(NUM_IMG_ROWS);

    typedef enum logic [1:0] {
        MODE_SHIFT_FETCH = 2'b00,
        MODE_SHIFT_PAD   = 2'b01,
        MODE_INIT        = 2'b10,
        MODE_CLEAR       = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_FETCH_REQ  = 3'd2,
        ST_FETCH_WAIT = 3'd3,
        ST_FETCH_GAP  = 3'd4,
        ST_COMMIT     = 3'd5,
        ST_DONE       = 3'd6
    } state_e;

    state_e                          state;
    mode_e                           mode_q;
    logic [ROW_AW-1:0]               row_q;
    logic [RXW-1:0]                  cur_row;
    logic [TIW-1:0]                  tgt_idx;
    logic [TIW-1:0]                  tgt_last;
    logic [WAW-1:0]                  word_k;
    logic                            done_q;
    logic [BRAM_AW-1:0]              addr_q;
    logic [NUM_ROWS*ROW_BITS-1:0]    win;
    logic [(NUM_ROWS-1)*ROW_BITS-1:0] stage;
    logic [ROW_BITS-1:0]             start_q;

    // Row numbers carry extra high bits so that latched row + i past the ROW_AW range reads as off-image.
    logic [RXW-1:0] first_row;
    logic [RXW-1:0] next_row;
    logic           first_invalid;
    logic           cur_invalid;
    logic           next_invalid;
    logic [WAW-1:0] word_nxt;
    logic [SIW-1:0] stage_lsb;

    assign first_row     = {{TIW{1'b0}}, row_q};
    assign next_row      = cur_row + 1'b1;
    assign first_invalid = first_row >= IMG_ROWS;
    assign cur_invalid   = cur_row >= IMG_ROWS;
    assign next_invalid  = next_row >= IMG_ROWS;
    assign word_nxt      = word_k + 1'b1;
    assign stage_lsb     = SIW'(tgt_idx) * SIW'(ROW_BITS) + SIW'(word_k) * SIW'(BRAM_DW);

    assign o_window         = win;
    assign o_done           = done_q & i_trig;
    assign o_busy           = state != ST_IDLE;
    assign bram.o_bram_addr = addr_q;
    // Trig drops in the cycle done is seen, so a 1-cycle BRAM costs REQ + WAIT + GAP = 3 cycles per word.
    assign bram.o_bram_trig = (state == ST_FETCH_REQ) ||
                              ((state == ST_FETCH_WAIT) && !bram.i_bram_done);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_SHIFT_FETCH;
            row_q    <= '0;
            cur_row  <= '0;
            tgt_idx  <= '0;
            tgt_last <= '0;
            word_k   <= '0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            win      <= '0;
            stage    <= '0;
            start_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (i_trig) begin
                        mode_q <= mode_e'(i_mode);
                        row_q  <= i_row_num;
                        state  <= ST_START;
                    end
                end
                ST_START: begin
                    stage   <= '0;
                    cur_row <= first_row;
                    tgt_idx <= '0;
                    word_k  <= '0;
                    addr_q  <= {row_q, {WAW{1'b0}}};
                    case (mode_q)
                        MODE_SHIFT_FETCH: begin
                            tgt_last <= '0;
                            state    <= first_invalid ? ST_FETCH_GAP : ST_FETCH_REQ;
                        end
                        MODE_INIT: begin
                            start_q  <= i_start_row_data;
                            tgt_last <= TIW'(NUM_ROWS - 2);
                            state    <= first_invalid ? ST_FETCH_GAP : ST_FETCH_REQ;
                        end
                        default: state <= ST_COMMIT;
                    endcase
                end
                ST_FETCH_REQ: state <= ST_FETCH_WAIT;
                ST_FETCH_WAIT: begin
                    if (bram.i_bram_done) begin
                        stage[stage_lsb +: BRAM_DW] <= bram.i_bram_data;
                        state <= ST_FETCH_GAP;
                    end
                end
                ST_FETCH_GAP: begin
                    // Off-image targets stay zero from the START clear and pass through here in one cycle.
                    if (cur_invalid || !bram.i_bram_done) begin
                        if (!cur_invalid && word_k != LAST_WORD) begin
                            word_k <= word_nxt;
                            addr_q <= {cur_row[ROW_AW-1:0], word_nxt};
                            state  <= ST_FETCH_REQ;
                        end else if (tgt_idx == tgt_last) begin
                            state <= ST_COMMIT;
                        end else begin
                            tgt_idx <= tgt_idx + 1'b1;
                            cur_row <= next_row;
                            word_k  <= '0;
                            addr_q  <= {next_row[ROW_AW-1:0], {WAW{1'b0}}};
                            state   <= next_invalid ? ST_FETCH_GAP : ST_FETCH_REQ;
                        end
                    end
                end
                ST_COMMIT: begin
                    case (mode_q)
                        MODE_SHIFT_FETCH: win <= {stage[ROW_BITS-1:0], win[NUM_ROWS*ROW_BITS-1:ROW_BITS]};
                        MODE_SHIFT_PAD:   win <= {{ROW_BITS{1'b0}}, win[NUM_ROWS*ROW_BITS-1:ROW_BITS]};
                        MODE_INIT:        win <= {stage, start_q};
                        default:          win <= '0;
                    endcase
                    done_q <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (!i_trig) begin
                        done_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_row_window_shifter.sv
// tb/tb_row_window_shifter.sv - directed vector bench for row_window_shifter with a data=address BRAM model.
module tb_row_window_shifter;
    localparam int ROW_BITS     = 512;
    localparam int NUM_ROWS     = 3;
    localparam int ROW_AW       = 9;
    localparam int BRAM_DW      = 32;
    localparam int BRAM_AW      = 13;
    localparam int NUM_IMG_ROWS = 512;
    localparam int W            = ROW_BITS / BRAM_DW;
    localparam int Z            = -1;
    localparam int S            = -2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst;
    logic                         trig;
    logic [1:0]                   mode;
    logic [ROW_AW-1:0]            row_num;
    logic [ROW_BITS-1:0]          start_data;
    logic                         done;
    logic                         busy;
    logic [NUM_ROWS*ROW_BITS-1:0] window;

    row_window_shifter_if #(.BRAM_DW(BRAM_DW), .BRAM_AW(BRAM_AW)) bif ();

    row_window_shifter #(
        .ROW_BITS(ROW_BITS), .NUM_ROWS(NUM_ROWS), .ROW_AW(ROW_AW),
        .BRAM_DW(BRAM_DW), .BRAM_AW(BRAM_AW), .NUM_IMG_ROWS(NUM_IMG_ROWS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_trig(trig), .i_mode(mode), .i_row_num(row_num),
        .i_start_row_data(start_data), .o_done(done), .o_busy(busy), .o_window(window),
        .bram(bif)
    );

    // BRAM model: data = word address, done after lat cycles of trig, low one cycle after trig drops.
    bit rnd_lat = 1'b0;
    int lat = 1;
    int cnt = 1;
    always @(posedge clk) begin
        if (rst || !bif.o_bram_trig) begin
            bif.i_bram_done <= 1'b0;
            bif.i_bram_data <= 32'hDEADBEEF;
            cnt <= 1;
            lat <= rnd_lat ? int'($urandom_range(7, 1)) : 1;
        end else if (!bif.i_bram_done) begin
            if (cnt >= lat) begin
                bif.i_bram_done <= 1'b1;
                bif.i_bram_data <= BRAM_DW'(bif.o_bram_addr);
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    int tot_reqs = 0;
    int hs_err = 0;
    int addr_log [0:1023];
    logic trig_d = 1'b0;
    logic [BRAM_AW-1:0] addr_d = '0;
    always @(negedge clk) begin
        if (bif.o_bram_trig && !trig_d) begin
            if (bif.i_bram_done) hs_err++;
            if (tot_reqs < 1024) addr_log[tot_reqs] = int'(bif.o_bram_addr);
            tot_reqs++;
        end else if (bif.o_bram_trig && trig_d && bif.o_bram_addr !== addr_d) begin
            hs_err++;
        end
        trig_d = bif.o_bram_trig;
        addr_d = bif.o_bram_addr;
    end

    typedef struct {
        logic [1:0] mode;
        int         row;
        logic [7:0] sbyte;
        int         exp0;
        int         exp1;
        int         exp2;
        int         reqs;
        int         first;
        int         done_at;
        bit         rnd;
    } vec_t;

    vec_t vecs [10];
    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_row(input string nm, input int r, input logic [ROW_BITS-1:0] act,
                             input logic [ROW_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row%0d: got %h expected %h", nm, r, act, exp);
        end
    endtask

    function automatic logic [ROW_BITS-1:0] row_val(input int code, input logic [7:0] sb);
        logic [ROW_BITS-1:0] r;
        r = '0;
        if (code == S) r = {(ROW_BITS/8){sb}};
        else if (code >= 0)
            for (int k = 0; k < W; k++) r[k*BRAM_DW +: BRAM_DW] = BRAM_DW'(code * W + k);
        return r;
    endfunction

    function automatic int code_of(input vec_t v, input int r);
        case (r)
            0:       return v.exp0;
            1:       return v.exp1;
            default: return v.exp2;
        endcase
    endfunction

    task automatic check_window(input string nm, input vec_t v);
        for (int r = 0; r < NUM_ROWS; r++)
            check_row(nm, r, window[r*ROW_BITS +: ROW_BITS], row_val(code_of(v, r), v.sbyte));
    endtask

    task automatic check_reqs(input string nm, input int base, input vec_t v);
        int got;
        bit bad;
        got = tot_reqs - base;
        check({nm, " bram requests"}, 64'(got), 64'(v.reqs));
        if (v.reqs > 0) begin
            check({nm, " first addr"}, 64'(addr_log[base]), 64'(v.first));
            bad = 1'b0;
            for (int j = 1; j < got && base + j < 1024; j++)
                if (addr_log[base+j] != addr_log[base+j-1] + 1) bad = 1'b1;
            check({nm, " addr sequence"}, 64'(bad), 64'd0);
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        logic [NUM_ROWS*ROW_BITS-1:0] prev;
        int  n;
        int  base;
        bit  seen;
        bit  changed;
        @(negedge clk);
        rnd_lat    = v.rnd;
        prev       = window;
        base       = tot_reqs;
        mode       = v.mode;
        row_num    = v.row[ROW_AW-1:0];
        start_data = {(ROW_BITS/8){v.sbyte}};
        trig       = 1'b1;
        n = -1;
        seen = 1'b0;
        changed = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (window !== prev) changed = 1'b1;
        end
        check({nm, " reached done"}, 64'(seen), 64'd1);
        if (v.done_at >= 0) check({nm, " done edge"}, 64'(n), 64'(v.done_at));
        check({nm, " window held before commit"}, 64'(changed), 64'd0);
        check_window(nm, v);
        check_reqs(nm, base, v);
        trig = 1'b0;
        #1;
        check({nm, " done falls with trig"}, 64'(done), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({nm, " idle after done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t va;
        int   base;
        bit   idle;
        bit   seen_done;
        bit   found;

        vecs[0] = '{2'b10, 10,  8'hA5, S,   10,  11,  32, 160,  98, 1'b0};
        vecs[1] = '{2'b00, 12,  8'h00, 10,  11,  12,  16, 192,  50, 1'b0};
        vecs[2] = '{2'b01, 0,   8'h00, 11,  12,  Z,   0,  0,    2,  1'b0};
        vecs[3] = '{2'b01, 0,   8'h00, 12,  Z,   Z,   0,  0,    2,  1'b0};
        vecs[4] = '{2'b10, 511, 8'h3C, S,   511, Z,   16, 8176, 51, 1'b0};
        vecs[5] = '{2'b00, 0,   8'h00, 511, Z,   0,   16, 0,    50, 1'b0};
        vecs[6] = '{2'b00, 511, 8'h00, Z,   0,   511, 16, 8176, 50, 1'b0};
        vecs[7] = '{2'b11, 0,   8'h00, Z,   Z,   Z,   0,  0,    2,  1'b0};
        vecs[8] = '{2'b10, 200, 8'h5A, S,   200, 201, 32, 3200, -1, 1'b1};
        vecs[9] = '{2'b00, 7,   8'h00, 200, 201, 7,   16, 112,  -1, 1'b1};

        rst = 1'b1;
        trig = 1'b1;
        mode = 2'b00;
        row_num = '0;
        start_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset window", 64'(window != '0), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset bram trig", 64'(bif.o_bram_trig), 64'd0);
        check("reset bram addr", 64'(bif.o_bram_addr), 64'd0);
        trig = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // trig withdrawn mid-fetch: the shift still commits, o_done never shows
        @(negedge clk);
        rnd_lat = 1'b0;
        base = tot_reqs;
        mode = 2'b00;
        row_num = 9'd3;
        trig = 1'b1;
        repeat (10) @(negedge clk);
        trig = 1'b0;
        idle = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 500 && !idle; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (!busy) idle = 1'b1;
        end
        va = '{2'b00, 3, 8'h00, 201, 7, 3, 16, 48, -1, 1'b0};
        check("drop back to idle", 64'(idle), 64'd1);
        check("drop done stays low", 64'(seen_done), 64'd0);
        check_window("drop", va);
        check_reqs("drop", base, va);

        // reset in the middle of word 5 of a fetch
        @(negedge clk);
        mode = 2'b00;
        row_num = 9'd20;
        trig = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bif.o_bram_trig && bif.o_bram_addr == BRAM_AW'(20 * W + 5)) found = 1'b1;
        end
        check("reached word 5", 64'(found), 64'd1);
        rst = 1'b1;
        trig = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset window", 64'(window != '0), 64'd0);
        check("midreset bram trig", 64'(bif.o_bram_trig), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset bram addr", 64'(bif.o_bram_addr), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        rst = 1'b0;

        run_op(vecs[0], "post-reset init");

        check("handshake violations", 64'(hs_err), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
